hazard_forward_unit: RTL
========================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL take parameter NUM_SRC, default 2: number of source operands per instruction (legal values 2..3).
REQ-002 The block SHALL take parameter LOAD_USE_CYCLES, default 1: number of bubble cycles inserted per load-use hazard (legal values 1..3).
REQ-003 The block SHALL take parameter CNT_W, default 32: width of each performance counter.
REQ-004 The block SHALL have port clk  in  1  pipeline clock.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port id_rs_i  in  NUM_SRC x rv32i_reg  source registers of the instruction in IF/ID.
REQ-007 The block SHALL have port id_rs_used_i  in  NUM_SRC  per-source valid flag for the IF/ID instruction.
REQ-008 The block SHALL have port ex_rs_i  in  NUM_SRC x rv32i_reg  source registers of the instruction in ID/EX.
REQ-009 The block SHALL have ports ex_rd_i  in  rv32i_reg  and ex_is_load_i  in  1  (ID/EX destination; ID/EX holds a load).
REQ-010 The block SHALL have ports mem_rd_i  in  rv32i_reg, mem_load_regfile_i  in  1 and mem_is_load_i  in  1  (EX/MEM stage).
REQ-011 The block SHALL have ports wb_rd_i  in  rv32i_reg  and wb_load_regfile_i  in  1  (MEM/WB stage).
REQ-012 The block SHALL have ports dmem_req_i  in  1  and dmem_resp_i  in  1  (data memory request outstanding; response this cycle).
REQ-013 The block SHALL have port fwd_sel_o  out  NUM_SRC x forwardingmux_sel_t  per-source operand mux select.
REQ-014 The block SHALL have ports pc_stall_o, if_id_stall_o, id_ex_bubble_o and freeze_o, each  out  1.
REQ-015 The block SHALL have ports loaduse_cnt_o and freeze_cnt_o, each  out  CNT_W  (performance counters).

Function
REQ-016 fwd_sel_o[i] SHALL be combinational: ex_mem when mem_load_regfile_i & mem_rd_i!=0 & mem_rd_i==ex_rs_i[i] & ~mem_is_load_i.
REQ-017 Otherwise fwd_sel_o[i] SHALL be mem_wb when wb_load_regfile_i & wb_rd_i!=0 & wb_rd_i==ex_rs_i[i].
REQ-018 Otherwise fwd_sel_o[i] SHALL be id_ex; each source is evaluated independently and the EX/MEM (youngest) match always wins.
REQ-019 A hazard SHALL exist when ex_is_load_i & ex_rd_i!=0 & any i with id_rs_used_i[i] & id_rs_i[i]==ex_rd_i.
REQ-020 freeze_o SHALL equal dmem_req_i & ~dmem_resp_i, combinationally.
REQ-021 The FSM SHALL have two states, RUN and LOAD_USE, with a 2-bit down-counter luc.
REQ-022 In RUN with a hazard and freeze_o=0: pc_stall_o, if_id_stall_o and id_ex_bubble_o SHALL be 1 that cycle; if LOAD_USE_CYCLES>1, the FSM SHALL go to LOAD_USE with luc=LOAD_USE_CYCLES-1, else it SHALL stay in RUN.
REQ-023 In LOAD_USE with freeze_o=0: the three stall outputs SHALL be 1; hazard detection SHALL be masked; luc SHALL decrement; at luc==1 the FSM SHALL go to RUN.
REQ-024 When freeze_o=1: pc_stall_o and if_id_stall_o SHALL be 1, id_ex_bubble_o SHALL be 0, and the FSM state and luc SHALL hold.
REQ-025 Freeze SHALL take priority over hazard; a hazard pending during freeze SHALL be acted on in the first unfrozen cycle.
REQ-026 loaduse_cnt_o SHALL increment on each cycle with id_ex_bubble_o=1, and freeze_cnt_o on each cycle with freeze_o=1.
REQ-027 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 When not in a load-use stall and not frozen, all stall/bubble outputs SHALL be 0.

Reset
REQ-029 rst SHALL asynchronously force state RUN, luc=0 and both counters=0, including in the middle of a LOAD_USE stall.
REQ-030 Combinational outputs SHALL follow their equations during reset, with FSM-derived terms taken from state RUN.

Structure
REQ-031 forwardingmux_sel_t SHALL stay in the shared forwardingmux package; the hazard state enum SHALL be added to rv32i_types.
REQ-032 The block SHALL instantiate a sub-module fwd_sel once per source, performing the REQ-016..018 compare/priority for a single operand.

Verification
REQ-033 ex_rs_i[0]=5, mem_rd_i=5, mem_load_regfile_i=1, wb_rd_i=5, wb_load_regfile_i=1 -> fwd_sel_o[0]=ex_mem.
REQ-034 ex_rs_i[1]=0, mem_rd_i=0, mem_load_regfile_i=1 -> fwd_sel_o[1]=id_ex.
REQ-035 LOAD_USE_CYCLES=2, ex_is_load_i=1, ex_rd_i=7, id_rs_i[1]=7, id_rs_used_i[1]=1 -> stalls and bubble high exactly 2 cycles, then loaduse_cnt_o=2.
REQ-036 Hazard raised together with dmem_req_i=1 for 3 cycles, then dmem_resp_i=1 -> freeze_o high 3 cycles with no bubble, then the bubble starts; freeze_cnt_o=3.
REQ-037 rst asserted during the 2nd LOAD_USE cycle -> state RUN, counters 0, stall outputs 0 immediately.
REQ-038 CNT_W=4 with 20 freeze cycles -> freeze_cnt_o holds at 15.

Source files
------------

// File: rtl/forwardingmux.sv
// Shared operand-forwarding mux select encoding used by the EX stage.
package forwardingmux;

  typedef enum logic [1:0] {
    id_ex  = 2'b00,
    ex_mem = 2'b01,
    mem_wb = 2'b10
  } forwardingmux_sel_t;

endpackage

// File: rtl/rv32i_types.sv
// Common RV32I pipeline types: register index and hazard-unit FSM state.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic {
    RUN      = 1'b0,
    LOAD_USE = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for a single EX-stage source operand; EX/MEM beats MEM/WB.
module fwd_sel
  import forwardingmux::*;
  import rv32i_types::*;
(
  input  rv32i_reg           ex_rs_i,
  input  rv32i_reg           mem_rd_i,
  input  logic               mem_load_regfile_i,
  input  logic               mem_is_load_i,
  input  rv32i_reg           wb_rd_i,
  input  logic               wb_load_regfile_i,
  output forwardingmux_sel_t sel_o
);

  logic mem_hit;
  logic wb_hit;

  // Load data is not available until MEM/WB, so a load in EX/MEM never forwards.
  assign mem_hit = mem_load_regfile_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i) && !mem_is_load_i;
  assign wb_hit  = wb_load_regfile_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i);

  always_comb begin
    sel_o = id_ex;
    if (mem_hit)     sel_o = ex_mem;
    else if (wb_hit) sel_o = mem_wb;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: per-operand forwarding, load-use stall FSM, dmem freeze
// and saturating performance counters.
module hazard_forward_unit
  import forwardingmux::*;
  import rv32i_types::*;
#(
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  rv32i_reg           [NUM_SRC-1:0]     id_rs_i,
  input  logic               [NUM_SRC-1:0]     id_rs_used_i,
  input  rv32i_reg           [NUM_SRC-1:0]     ex_rs_i,
  input  rv32i_reg                             ex_rd_i,
  input  logic                                 ex_is_load_i,
  input  rv32i_reg                             mem_rd_i,
  input  logic                                 mem_load_regfile_i,
  input  logic                                 mem_is_load_i,
  input  rv32i_reg                             wb_rd_i,
  input  logic                                 wb_load_regfile_i,
  input  logic                                 dmem_req_i,
  input  logic                                 dmem_resp_i,
  output forwardingmux_sel_t [NUM_SRC-1:0]     fwd_sel_o,
  output logic                                 pc_stall_o,
  output logic                                 if_id_stall_o,
  output logic                                 id_ex_bubble_o,
  output logic                                 freeze_o,
  output logic               [CNT_W-1:0]       loaduse_cnt_o,
  output logic               [CNT_W-1:0]       freeze_cnt_o
);

  localparam logic [1:0] LUC_INIT = 2'(LOAD_USE_CYCLES - 1);

  hazard_state_t state, state_n;
  logic [1:0]    luc, luc_n;
  logic          hazard;
  logic          stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_sel u_fwd_sel (
      .ex_rs_i            (ex_rs_i[i]),
      .mem_rd_i           (mem_rd_i),
      .mem_load_regfile_i (mem_load_regfile_i),
      .mem_is_load_i      (mem_is_load_i),
      .wb_rd_i            (wb_rd_i),
      .wb_load_regfile_i  (wb_load_regfile_i),
      .sel_o              (fwd_sel_o[i])
    );
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used_i[i] && (id_rs_i[i] == ex_rd_i)) hazard = 1'b1;
    end
    hazard = hazard && ex_is_load_i && (ex_rd_i != '0);
  end

  assign freeze_o = dmem_req_i && !dmem_resp_i;

  // Freeze holds state and luc; a hazard seen while frozen is re-evaluated next cycle.
  always_comb begin
    state_n = state;
    luc_n   = luc;
    stall   = 1'b0;
    if (state == LOAD_USE) begin
      stall = 1'b1;
      if (!freeze_o) begin
        luc_n = luc - 2'd1;
        if (luc == 2'd1) state_n = RUN;
      end
    end else if (hazard) begin
      stall = 1'b1;
      if (!freeze_o && (LOAD_USE_CYCLES > 1)) begin
        state_n = LOAD_USE;
        luc_n   = LUC_INIT;
      end
    end
  end

  assign pc_stall_o     = stall || freeze_o;
  assign if_id_stall_o  = stall || freeze_o;
  assign id_ex_bubble_o = stall && !freeze_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      luc           <= '0;
      loaduse_cnt_o <= '0;
      freeze_cnt_o  <= '0;
    end else begin
      state <= state_n;
      luc   <= luc_n;
      if (id_ex_bubble_o && (loaduse_cnt_o != '1)) loaduse_cnt_o <= loaduse_cnt_o + CNT_W'(1);
      if (freeze_o && (freeze_cnt_o != '1))        freeze_cnt_o  <= freeze_cnt_o + CNT_W'(1);
    end
  end

endmodule
